// File: rtl/film_pkg.sv
// Shared types and constants for the old-film scratch overlay.
// Slot layout plus the brighten helper used by the blend stage.
package film_pkg;

  localparam int PIX_W       = 24;
  localparam int COORD_W     = 10;
  localparam int NUM_SCRATCH = 2;

  localparam logic [7:0] SCRATCH_WHITE = 8'hFF;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [3:0]         life;
  } slot_t;

  typedef struct packed {
    logic             valid;
    logic             sof;
    logic             eol;
    logic             hit;
    logic [PIX_W-1:0] data;
  } s1_t;

  function automatic logic [7:0] brighten(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, SCRATCH_WHITE};
    return s[8:1];
  endfunction

endpackage

// File: rtl/film_scratch_overlay_if.sv
// Valid/ready RGB pixel stream with frame and line markers.
// master drives the pixel, slave returns ready.
interface film_scratch_overlay_if;
  import film_pkg::*;

  logic             valid;
  logic             ready;
  logic             sof;
  logic             eol;
  logic [PIX_W-1:0] data;

  modport master (
    output valid, sof, eol, data,
    input  ready
  );

  modport slave (
    input  valid, sof, eol, data,
    output ready
  );

endinterface

// File: rtl/scratch_slot.sv
// One scratch slot: shadow state updated per frame, live copy
// taken at start of frame, and the column hit test.
module scratch_slot
  import film_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int LIFE     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd,
  input  logic               drift_up,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic               load,
  input  logic [COORD_W-1:0] col,
  output logic               freed,
  output logic               hit
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);

  slot_t shadow_q, shadow_d;
  slot_t live_q, live_d;
  slot_t aged;

  always_comb begin
    aged = shadow_q;
    if (shadow_q.active) begin
      aged.life = shadow_q.life - 4'd1;
      if (aged.life == 4'd0) begin
        aged.active = 1'b0;
      end else if (drift_up) begin
        if (shadow_q.x != X_MAX) aged.x = shadow_q.x + 1'b1;
      end else begin
        if (shadow_q.x != '0) aged.x = shadow_q.x - 1'b1;
      end
    end
  end

  // freed already reflects an expiry on this update, so the
  // arbiter can hand the slot straight to a new scratch.
  assign freed = !aged.active;

  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    if (upd) begin
      if (spawn) begin
        shadow_d = slot_t'{
          active: 1'b1,
          x:      spawn_x,
          life:   4'(LIFE)
        };
      end else begin
        shadow_d = aged;
      end
    end
    if (load) live_d = shadow_q;
  end

  always_comb begin
    hit = 1'b0;
    if (load) begin
      hit = shadow_q.active && (shadow_q.x == col);
    end else begin
      hit = live_q.active && (live_q.x == col);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

endmodule

// File: rtl/film_scratch_overlay.sv
// Blends up to two drifting vertical scratches into a pixel
// stream through a two-stage valid/ready pipeline.
module film_scratch_overlay
  import film_pkg::*;
#(
  parameter int         H_ACTIVE   = 640,
  parameter int         LIFE       = 4,
  parameter logic [1:0] SPAWN_MASK = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame,
  input  logic [COORD_W-1:0]     rand_i,
  film_scratch_overlay_if.slave  in_if,
  film_scratch_overlay_if.master out_if
);

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] WRAP  = COORD_W'(1024 - H_ACTIVE);

  logic frame_d_q, frame_d_d;
  logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
  s1_t s1_q, s1_d;
  logic out_valid_q, out_valid_d;
  logic out_sof_q, out_sof_d;
  logic out_eol_q, out_eol_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  logic adv;
  logic acc;
  logic load;
  logic hit;
  logic spawn_ok;
  logic taken;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] spawn_x;
  logic [NUM_SCRATCH-1:0] freed;
  logic [NUM_SCRATCH-1:0] grant;
  logic [NUM_SCRATCH-1:0] hits;

  assign adv  = out_if.ready || !out_valid_q;
  assign acc  = in_if.valid && adv;
  assign load = acc && in_if.sof;
  assign col  = in_if.sof ? '0 : x_cnt_q;
  assign hit  = |hits;

  assign spawn_x  = (rand_i < H_LIM) ? rand_i : rand_i - WRAP;
  assign spawn_ok = frame_d_q && ((rand_i[1:0] & SPAWN_MASK) == 2'b00);

  always_comb begin
    grant = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (spawn_ok && freed[i] && !taken) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SCRATCH; i++) begin : g_slot
    scratch_slot #(
      .H_ACTIVE (H_ACTIVE),
      .LIFE     (LIFE)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .upd      (frame_d_q),
      .drift_up (rand_i[2]),
      .spawn    (grant[i]),
      .spawn_x  (spawn_x),
      .load     (load),
      .col      (col),
      .freed    (freed[i]),
      .hit      (hits[i])
    );
  end

  always_comb begin
    frame_d_d   = frame;
    x_cnt_d     = x_cnt_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_data_d  = out_data_q;
    if (acc) begin
      if (in_if.eol)        x_cnt_d = '0;
      else if (col == '1)   x_cnt_d = col;
      else                  x_cnt_d = col + 1'b1;
    end
    if (adv) begin
      s1_d = s1_t'{
        valid: in_if.valid,
        sof:   in_if.valid && in_if.sof,
        eol:   in_if.valid && in_if.eol,
        hit:   in_if.valid && hit,
        data:  in_if.data
      };
      out_valid_d = s1_q.valid;
      out_sof_d   = s1_q.sof;
      out_eol_d   = s1_q.eol;
      if (s1_q.hit) begin
        out_data_d = {brighten(s1_q.data[23:16]),
                      brighten(s1_q.data[15:8]),
                      brighten(s1_q.data[7:0])};
      end else begin
        out_data_d = s1_q.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_d_q   <= 1'b0;
      x_cnt_q     <= '0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      frame_d_q   <= frame_d_d;
      x_cnt_q     <= x_cnt_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_if.ready  = adv;
  assign out_if.valid = out_valid_q;
  assign out_if.sof   = out_sof_q;
  assign out_if.eol   = out_eol_q;
  assign out_if.data  = out_data_q;

endmodule

// File: tb/tb_film_scratch_overlay.sv
// Directed bench for film_scratch_overlay: DUT A uses LIFE=4,
// DUT B uses LIFE=15 so the right-edge clamp is reachable.
module tb_film_scratch_overlay;
  import film_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        frame;
  logic [9:0]  rand_i;
  logic        in_valid;
  logic        in_sof;
  logic        in_eol;
  logic [23:0] in_data;
  logic        out_ready;

  film_scratch_overlay_if ina ();
  film_scratch_overlay_if inb ();
  film_scratch_overlay_if outa ();
  film_scratch_overlay_if outb ();

  assign ina.valid  = in_valid;
  assign ina.sof    = in_sof;
  assign ina.eol    = in_eol;
  assign ina.data   = in_data;
  assign inb.valid  = in_valid;
  assign inb.sof    = in_sof;
  assign inb.eol    = in_eol;
  assign inb.data   = in_data;
  assign outa.ready = out_ready;
  assign outb.ready = out_ready;

  film_scratch_overlay #(
    .H_ACTIVE   (640),
    .LIFE       (4),
    .SPAWN_MASK (2'b11)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .frame  (frame),
    .rand_i (rand_i),
    .in_if  (ina),
    .out_if (outa)
  );

  film_scratch_overlay #(
    .H_ACTIVE   (640),
    .LIFE       (15),
    .SPAWN_MASK (2'b11)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .frame  (frame),
    .rand_i (rand_i),
    .in_if  (inb),
    .out_if (outb)
  );

  int total = 0;
  int bad   = 0;
  int nout  = 0;
  int c0 = -1, c1 = -1, b0 = -1, b1 = -1;
  bit chk_b = 0;
  bit rnd = 0;
  bit acc = 0;
  bit hold_chk = 0;
  logic [23:0] held;
  logic [49:0] nxt;
  logic [49:0] expq[$];

  function automatic logic [7:0] br(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + 9'd255;
    return s[8:1];
  endfunction

  function automatic logic [23:0] blend(input logic [23:0] d);
    return {br(d[23:16]), br(d[15:8]), br(d[7:0])};
  endfunction

  function automatic logic [23:0] pix(input int col);
    logic [9:0] c;
    c = col[9:0];
    return {8'h20, c[7:0], 8'hE0 ^ c[9:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [49:0] e;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (hold_chk) chk("stall_hold", 32'(outa.data), 32'(held));
    acc = in_valid && ina.ready;
    if (acc) expq.push_back(nxt);
    if (outa.valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_out", 32'(expq.size()), 1);
      end else begin
        e = expq.pop_front();
        chk("out_data", 32'(outa.data), 32'(e[23:0]));
        chk("out_sofeol", 32'({outa.sof, outa.eol}), 32'(e[49:48]));
        if (chk_b) chk("outb_data", 32'(outb.data), 32'(e[47:24]));
        nout++;
      end
    end
    hold_chk = outa.valid && !out_ready;
    held     = outa.data;
    @(negedge clk);
  endtask

  task automatic send_px(input logic s, input logic e, input int col);
    logic [23:0] d;
    logic [23:0] ea;
    logic [23:0] eb;
    d  = pix(col);
    ea = (col == c0 || col == c1) ? blend(d) : d;
    eb = (col == b0 || col == b1) ? blend(d) : d;
    in_valid = 1'b1;
    in_sof   = s;
    in_eol   = e;
    in_data  = d;
    nxt      = {s, e, eb, ea};
    for (int k = 0; k < 64; k++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic send_span(input int lo, input int hi, input bit sof);
    for (int c = lo; c <= hi; c++) begin
      send_px(sof && (c == lo), c == 639, c);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    rnd       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (expq.size() != 0) step();
    end
    chk("drain_empty", 32'(expq.size()), 0);
  endtask

  task automatic pulse(input logic [9:0] r);
    frame = 1'b1;
    step();
    frame  = 1'b0;
    rand_i = r;
    step();
    step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    frame    = 1'b0;
    step();
    step();
    rst = 1'b0;
    expq.delete();
    hold_chk = 1'b0;
    c0 = -1; c1 = -1; b0 = -1; b1 = -1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    frame     = 1'b0;
    rand_i    = '0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_eol    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    #1;
    chk("rst_out_valid", 32'(outa.valid), 0);
    chk("rst_out_sof", 32'(outa.sof), 0);
    chk("rst_out_eol", 32'(outa.eol), 0);
    chk("rst_out_data", 32'(outa.data), 0);
    chk("rst_in_ready", 32'(ina.ready), 1);
    @(negedge clk);
    out_ready = 1'b1;

    // two-cycle latency on a single pixel
    send_px(1'b1, 1'b0, 0);
    #1;
    chk("lat_s1_valid", 32'(outa.valid), 0);
    step();
    #1;
    chk("lat_s2_valid", 32'(outa.valid), 1);
    chk("lat_s2_data", 32'(outa.data), 32'h200000 ^ 32'h0000E0);
    chk("lat_s2_sof", 32'(outa.sof), 1);
    drain();

    // spawn at 256; 0x20 red channel becomes 0x8F there
    pulse(10'h100);
    c0 = 256;
    send_span(0, 639, 1'b1);
    drain();

    // drift up, down, down, then expire after four updates
    pulse(10'h005);
    c0 = 257;
    send_span(0, 639, 1'b1);
    drain();
    pulse(10'h001);
    pulse(10'h001);
    c0 = 255;
    send_span(0, 639, 1'b1);
    drain();
    pulse(10'h001);
    c0 = -1;
    send_span(0, 639, 1'b1);
    drain();

    // fold of a large random word: 900 -> 516
    pulse(10'd900);
    c0 = 516;
    send_span(0, 639, 1'b1);
    drain();

    // clamps at 0 and 639 (B keeps its scratches longer)
    do_reset();
    chk_b = 1'b1;
    pulse(10'd0);
    pulse(10'h001);
    c0 = 0; b0 = 0;
    send_span(0, 639, 1'b1);
    drain();
    pulse(10'd636);
    pulse(10'h005);
    pulse(10'h005);
    pulse(10'h005);
    c0 = 639; c1 = -1;
    b0 = 4;   b1 = 639;
    send_span(0, 639, 1'b1);
    drain();
    pulse(10'h005);
    c0 = -1;
    b0 = 5;   b1 = 639;
    send_span(0, 639, 1'b1);
    drain();
    chk_b = 1'b0;

    // both slots busy, then expire-and-spawn on one update
    do_reset();
    pulse(10'h100);
    pulse(10'h200);
    pulse(10'h300);
    c0 = 254; c1 = 511;
    send_span(0, 639, 1'b1);
    drain();
    pulse(10'h001);
    pulse(10'h080);
    c0 = 128; c1 = 509;
    send_span(0, 639, 1'b1);
    drain();

    // update mid-frame leaves the running frame alone
    send_span(0, 299, 1'b1);
    pulse(10'h001);
    send_span(300, 639, 1'b0);
    drain();
    c0 = 127; c1 = -1;
    send_span(0, 639, 1'b1);
    drain();

    // reset mid-line with a coincident frame pulse
    send_span(0, 99, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    frame    = 1'b1;
    rand_i   = 10'h100;
    step();
    #1;
    chk("rst_flush", 32'(outa.valid), 0);
    frame = 1'b0;
    step();
    rst = 1'b0;
    expq.delete();
    hold_chk = 1'b0;
    c0 = -1; c1 = -1;
    send_span(0, 639, 1'b1);
    drain();

    // random backpressure over a 640x4 frame
    pulse(10'h100);
    pulse(10'h200);
    c0 = 255; c1 = 512;
    nout = 0;
    rnd  = 1'b1;
    send_span(0, 639, 1'b1);
    for (int l = 1; l < 4; l++) send_span(0, 639, 1'b0);
    drain();
    chk("frame_count", 32'(nout), 2560);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
